load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_byte_lane.sv | 36 +++
 rtl/load_store_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int WORD_ADDR_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        DONE
    } lsuState_t;

    // Little-endian byte lane selectors, indexed by the low address bits.
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte extraction and byte merge for one 32-bit memory word (little-endian).
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] wordIn,
    input  logic [1:0]  lane,
    input  logic [7:0]  byteIn,
    output logic [7:0]  byteOut,
    output logic [31:0] mergedWord
);

    // Pick the addressed lane out of the word and replace only that lane in the merged copy.
    always_comb begin
        byteOut    = wordIn[7:0];
        mergedWord = wordIn;
        case (lane)
            LANE0: begin
                byteOut          = wordIn[7:0];
                mergedWord[7:0]  = byteIn;
            end
            LANE1: begin
                byteOut          = wordIn[15:8];
                mergedWord[15:8] = byteIn;
            end
            LANE2: begin
                byteOut           = wordIn[23:16];
                mergedWord[23:16] = byteIn;
            end
            LANE3: begin
                byteOut           = wordIn[31:24];
                mergedWord[31:24] = byteIn;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word and byte accesses to a synchronous-read data memory,
// with read-modify-write for byte stores and misalignment detection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_ADDR_W = WORD_ADDR_W_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Is_Store,
    input  logic        Is_Byte,
    input  logic [31:0] Addr,
    input  logic [31:0] Store_Data,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Load_Data,
    output logic        Misalign_Err,
    output logic        Mem_WrEn,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_DataIn,
    input  logic [31:0] Mem_DataOut
);

    lsuState_t   state;
    logic [1:0]  laneReg;
    logic [7:0]  storeByteReg;
    logic        isStoreReg;
    logic        isByteReg;
    logic        misReg;
    logic [31:0] loadReg;
    logic [31:0] memAddrReg;
    logic [31:0] dataInReg;
    logic [7:0]  laneByte;
    logic [31:0] laneMerged;

    // Address bits above the memory's word range wrap around and are deliberately dropped.
    logic unusedAddrHi;
    assign unusedAddrHi = ^Addr[31:WORD_ADDR_W+2];

    lsu_byte_lane byteLane (
        .wordIn     (Mem_DataOut),
        .lane       (laneReg),
        .byteIn     (storeByteReg),
        .byteOut    (laneByte),
        .mergedWord (laneMerged)
    );

    // Access sequencer: latches the request in IDLE and walks RD/RDW/WR/DONE as the access needs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            laneReg      <= 2'd0;
            storeByteReg <= 8'h0;
            isStoreReg   <= 1'b0;
            isByteReg    <= 1'b0;
            misReg       <= 1'b0;
            loadReg      <= 32'h0;
            memAddrReg   <= 32'h0;
            dataInReg    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        laneReg      <= Addr[1:0];
                        storeByteReg <= Store_Data[7:0];
                        isStoreReg   <= Is_Store;
                        isByteReg    <= Is_Byte;
                        memAddrReg   <= {{(30-WORD_ADDR_W){1'b0}}, Addr[WORD_ADDR_W+1:2], 2'b00};
                        if (!Is_Byte && (Addr[1:0] != 2'd0)) begin
                            misReg <= 1'b1;
                            state  <= DONE;
                        end else begin
                            misReg <= 1'b0;
                            if (Is_Store && !Is_Byte) begin
                                dataInReg <= Store_Data;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    state <= RDW;
                end
                RDW: begin
                    if (isStoreReg) begin
                        dataInReg <= laneMerged;
                        state     <= WR;
                    end else begin
                        loadReg <= isByteReg ? {24'h0, laneByte} : Mem_DataOut;
                        state   <= DONE;
                    end
                end
                WR: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Control strobes come from the state register only; Reset masks them so an aborted access never writes or completes.
    always_comb begin
        Busy         = !Reset && (state != IDLE);
        Done         = !Reset && (state == DONE);
        Mem_WrEn     = !Reset && (state == WR);
        Misalign_Err = !Reset && (state == DONE) && misReg;
    end

    assign Load_Data  = loadReg;
    assign Mem_Addr   = memAddrReg;
    assign Mem_DataIn = dataInReg;

endmodule
